// File: rtl/data_memory.sv
// Block-wide backing store for the data cache: 128-bit block reads/writes with a fixed
// multi-cycle latency announced through o_busywait.
module data_memory #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 5
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_read,
  input  logic         i_write,
  input  logic [27:0]  i_address,
  input  logic [127:0] i_writedata,
  output logic [127:0] o_readdata,
  output logic         o_busywait
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          r_state, w_state_next;
  logic [CntW-1:0] r_cnt, w_cnt_next;
  logic [IdxW-1:0] r_addr;
  logic [127:0]    r_wdata;
  logic            r_is_write;
  logic [127:0]    r_readdata;
  logic            w_busy;
  logic            w_accept;
  logic            w_access;

  logic [127:0] r_mem [DEPTH];

  // Upper address bits alias onto the array by design.
  logic w_unused_addr;
  assign w_unused_addr = ^i_address[27:IdxW];

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_busy       = 1'b0;
    w_accept     = 1'b0;
    w_access     = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_busy = i_read | i_write;
        if (i_read | i_write) begin
          w_accept     = 1'b1;
          w_cnt_next   = CntInit;
          w_state_next = StBusy;
        end
      end
      StBusy: begin
        w_busy = 1'b1;
        if (r_cnt == '0) begin
          w_access     = 1'b1;
          w_state_next = StDone;
        end else begin
          w_cnt_next = r_cnt - CntW'(1);
        end
      end
      StDone: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Reset must hold busywait low even while a request is presented.
  assign o_busywait = w_busy & i_rst_n;
  assign o_readdata = r_readdata;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_is_write <= 1'b0;
      r_readdata <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_addr     <= i_address[IdxW-1:0];
        r_wdata    <= i_writedata;
        r_is_write <= i_write;
      end
      if (w_access && !r_is_write) begin
        r_readdata <= r_mem[r_addr];
      end
    end
  end

  // Array is deliberately not reset; contents survive RESET.
  always_ff @(posedge i_clk) begin
    if (w_access && r_is_write) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: scoreboard of expected block results checked
// at each DONE cycle, plus latency, reset and back-to-back scenarios.
module tb_data_memory;

  localparam int unsigned DEPTH   = 256;
  localparam int unsigned LATENCY = 5;

  logic         clk;
  logic         rst_n;
  logic         i_read;
  logic         i_write;
  logic [27:0]  i_address;
  logic [127:0] i_writedata;
  logic [127:0] o_readdata;
  logic         o_busywait;

  int n_checks = 0;
  int n_errors = 0;

  logic [127:0] exp_q[$];
  logic [127:0] model_mem [int];
  logic [127:0] model_rd;

  data_memory #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_read      (i_read),
    .i_write     (i_write),
    .i_address   (i_address),
    .i_writedata (i_writedata),
    .o_readdata  (o_readdata),
    .o_busywait  (o_busywait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Push the expected READDATA at DONE for this request into the scoreboard.
  task automatic push_expected(input logic rd, input logic wr, input logic [27:0] addr,
                               input logic [127:0] data);
    int idx;
    idx = int'(addr % DEPTH);
    if (wr) begin
      model_mem[idx] = data;
    end else if (rd) begin
      model_rd = model_mem.exists(idx) ? model_mem[idx] : 128'hx;
    end
    exp_q.push_back(model_rd);
  endtask

  // Issue one request from IDLE; returns busy cycles after acceptance and READDATA at DONE.
  task automatic do_req(input logic rd, input logic wr, input logic [27:0] addr,
                        input logic [127:0] data, input bit hold,
                        output int cnt, output logic [127:0] rdata);
    @(negedge clk);
    i_read      = rd;
    i_write     = wr;
    i_address   = addr;
    i_writedata = data;
    push_expected(rd, wr, addr, data);
    @(posedge clk);
    #1;
    i_address   = addr ^ 28'h1;
    i_writedata = ~data;
    cnt = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!o_busywait) break;
      cnt++;
    end
    rdata = o_readdata;
    if (!hold) begin
      i_read  = 1'b0;
      i_write = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_read = 1'b1;
    i_write = 1'b0;
    i_address = 28'h0;
    i_writedata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (o_busywait !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_busywait got %b want 0", o_busywait);
    end
    n_checks++;
    if (o_readdata !== 128'h0) begin
      n_errors++;
      $display("FAIL reset_readdata got %h want 0", o_readdata);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (o_busywait !== 1'b1) begin
      n_errors++;
      $display("FAIL release_busywait got %b want 1", o_busywait);
    end
    i_read = 1'b0;
    model_rd = '0;
  endtask

  task automatic test_write_read();
    int cnt;
    logic [127:0] rd, exp;
    logic [127:0] d = 128'h44444444_33333333_22222222_11111111;
    do_req(1'b0, 1'b1, 28'h3, d, 1'b0, cnt, rd);
    exp = exp_q.pop_front();
    n_checks++;
    if (cnt != LATENCY) begin
      n_errors++;
      $display("FAIL wr_latency got %0d want %0d", cnt, LATENCY);
    end
    n_checks++;
    if (rd !== exp) begin
      n_errors++;
      $display("FAIL wr_readdata got %h want %h", rd, exp);
    end
    do_req(1'b1, 1'b0, 28'h3, '0, 1'b0, cnt, rd);
    exp = exp_q.pop_front();
    n_checks++;
    if (cnt != LATENCY) begin
      n_errors++;
      $display("FAIL rd_latency got %0d want %0d", cnt, LATENCY);
    end
    n_checks++;
    if (rd !== exp) begin
      n_errors++;
      $display("FAIL rd_data got %h want %h", rd, exp);
    end
    @(negedge clk);
    n_checks++;
    if (o_busywait !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_busywait got %b want 0", o_busywait);
    end
  endtask

  task automatic test_dual_op();
    int cnt;
    logic [127:0] rd, exp;
    logic [127:0] d = {16{8'hA5}};
    do_req(1'b1, 1'b1, 28'h7, d, 1'b0, cnt, rd);
    exp = exp_q.pop_front();
    n_checks++;
    if (rd !== exp) begin
      n_errors++;
      $display("FAIL dual_readdata_held got %h want %h", rd, exp);
    end
    do_req(1'b1, 1'b0, 28'h7, '0, 1'b0, cnt, rd);
    exp = exp_q.pop_front();
    n_checks++;
    if (rd !== exp) begin
      n_errors++;
      $display("FAIL dual_write_readback got %h want %h", rd, exp);
    end
  endtask

  task automatic test_alias();
    int cnt;
    logic [127:0] rd, exp;
    logic [127:0] d = 128'hDEADBEEF_01234567_89ABCDEF_DEADBEEF;
    do_req(1'b0, 1'b1, 28'h100, d, 1'b0, cnt, rd);
    void'(exp_q.pop_front());
    do_req(1'b1, 1'b0, 28'h0, '0, 1'b0, cnt, rd);
    exp = exp_q.pop_front();
    n_checks++;
    if (rd !== exp) begin
      n_errors++;
      $display("FAIL alias_read got %h want %h", rd, exp);
    end
  endtask

  task automatic test_reset_mid_op();
    int cnt;
    logic [127:0] rd, exp;
    logic [127:0] p1 = 128'h0F0F0F0F_1234ABCD_55AA55AA_C001D00D;
    do_req(1'b0, 1'b1, 28'h10, p1, 1'b0, cnt, rd);
    void'(exp_q.pop_front());
    @(negedge clk);
    i_write     = 1'b1;
    i_address   = 28'h10;
    i_writedata = ~p1;
    repeat (3) @(posedge clk);
    #1;
    rst_n   = 1'b0;
    i_write = 1'b0;
    #1;
    n_checks++;
    if (o_busywait !== 1'b0) begin
      n_errors++;
      $display("FAIL midreset_busywait got %b want 0", o_busywait);
    end
    n_checks++;
    if (o_readdata !== 128'h0) begin
      n_errors++;
      $display("FAIL midreset_readdata got %h want 0", o_readdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_rd = '0;
    do_req(1'b1, 1'b0, 28'h10, '0, 1'b0, cnt, rd);
    exp = exp_q.pop_front();
    n_checks++;
    if (rd !== exp) begin
      n_errors++;
      $display("FAIL midreset_contents got %h want %h", rd, exp);
    end
  endtask

  task automatic test_back_to_back();
    int cnt;
    logic [127:0] rd, exp;
    do_req(1'b0, 1'b1, 28'h1, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b0, cnt, rd);
    void'(exp_q.pop_front());
    do_req(1'b0, 1'b1, 28'h2, 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000, 1'b0, cnt, rd);
    void'(exp_q.pop_front());
    do_req(1'b1, 1'b0, 28'h1, '0, 1'b1, cnt, rd);
    exp = exp_q.pop_front();
    n_checks++;
    if (rd !== exp) begin
      n_errors++;
      $display("FAIL b2b_first got %h want %h", rd, exp);
    end
    // Still in DONE with READ held: new address is taken up only after returning to IDLE.
    i_address = 28'h2;
    push_expected(1'b1, 1'b0, 28'h2, '0);
    cnt = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!o_busywait) break;
      cnt++;
    end
    rd = o_readdata;
    i_read = 1'b0;
    exp = exp_q.pop_front();
    n_checks++;
    if (cnt != LATENCY + 1) begin
      n_errors++;
      $display("FAIL b2b_gap got %0d want %0d", cnt, LATENCY + 1);
    end
    n_checks++;
    if (rd !== exp) begin
      n_errors++;
      $display("FAIL b2b_second got %h want %h", rd, exp);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (o_busywait !== 1'b0 || o_readdata !== exp) begin
      n_errors++;
      $display("FAIL b2b_no_extra got busy=%b data=%h want busy=0 data=%h",
               o_busywait, o_readdata, exp);
    end
  endtask

  initial begin
    model_rd = '0;
    test_reset();
    test_write_read();
    test_dual_op();
    test_alias();
    test_reset_mid_op();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
